// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake direction scheduler.
package snake_pkg;

    typedef enum logic [2:0] {
        DIR_DOWN  = 3'd0,
        DIR_RIGHT = 3'd1,
        DIR_LEFT  = 3'd2,
        DIR_UP    = 3'd3,
        DIR_NONE  = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        F_IDLE,
        F_SETTLE,
        F_COMMIT
    } filt_state_t;

    // Opposite direction; NONE maps to itself.
    function automatic dir_t reverse(dir_t d);
        case (d)
            DIR_DOWN:  return DIR_UP;
            DIR_UP:    return DIR_DOWN;
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            default:   return DIR_NONE;
        endcase
    endfunction

    // Raw 3-bit keyboard code to dir_t; unused codes 5..7 collapse onto NONE.
    function automatic dir_t normalize(logic [2:0] code);
        if (code > 3'd4) return DIR_NONE;
        return dir_t'(code);
    endfunction

    // True for the four real movement directions.
    function automatic logic is_move(dir_t d);
        return (d != DIR_NONE);
    endfunction

endpackage

// File: rtl/dir_fifo.sv
// Pending-turn FIFO: DEPTH entries of dir_t with head/tail visibility and occupancy count.
module dir_fifo
    import snake_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  dir_t                     i_data,
    input  logic                     i_pop,
    output dir_t                     o_head,
    output dir_t                     o_tail,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    dir_t            r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   w_tail_ptr;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign w_tail_ptr = r_wr_ptr - AW'(1);
    assign o_head     = r_mem[r_rd_ptr];
    assign o_tail     = r_mem[w_tail_ptr];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage write.
    // NOTE: the array has no reset; entries are only ever read below the occupancy count, so stale contents are harmless and the RAM stays reset-free.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally; occupancy lives in its own saturating-by-construction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/snake_dir_scheduler.sv
// Keyboard-direction scheduler: synchronise, debounce, queue and apply one turn per game tick.
module snake_dir_scheduler
    import snake_pkg::*;
#(
    parameter int         DEPTH      = 4,
    parameter int         STABLE_CYC = 3,
    parameter logic [2:0] INIT_DIR   = 3'd1
) (
    input  logic                     clk_25,
    input  logic                     rst_n,
    input  logic [2:0]               kb_dir,
    input  logic                     game_tick,
    input  logic                     game_run,
    input  logic                     flush,
    output logic [2:0]               cur_dir,
    output logic                     turn_pulse,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     overflow
);

    localparam int   CNTW     = $clog2(STABLE_CYC + 1);
    localparam dir_t INIT_D   = dir_t'(INIT_DIR);

    // Synchroniser and filter state.
    logic [2:0]        r_sync1;
    logic [2:0]        r_sync2;
    dir_t              w_s;
    filt_state_t       r_fstate;
    logic [CNTW-1:0]   r_cnt;
    dir_t              r_cand;
    dir_t              r_last;
    logic              r_push_req;

    // Output / game-side state.
    dir_t              r_cur_dir;
    logic              r_turn_pulse;
    logic              r_overflow;

    // FIFO interface.
    dir_t                    w_head;
    dir_t                    w_tail;
    logic                    w_full;
    logic                    w_empty;
    logic [$clog2(DEPTH):0]  w_count;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop_full;
    logic                    w_accept;
    dir_t                    w_ref;

    // Two-flop synchroniser into clk_25; idles at NONE so reset never looks like a key.
    // NOTE: sequential state uses non-blocking assignments so r_sync2 takes the old r_sync1, giving a true two-stage chain.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= DIR_NONE;
            r_sync2 <= DIR_NONE;
        end else begin
            r_sync1 <= kb_dir;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = normalize(r_sync2);

    // Stability filter: a code must be seen STABLE_CYC times in a row before it is committed.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_fstate   <= F_IDLE;
            r_cnt      <= '0;
            r_cand     <= DIR_NONE;
            r_last     <= DIR_NONE;
            r_push_req <= 1'b0;
        end else begin
            r_push_req <= 1'b0;
            case (r_fstate)
                F_IDLE: begin
                    if (w_s != r_last) begin
                        r_cand <= w_s;
                        r_cnt  <= CNTW'(1);
                        if (STABLE_CYC == 1) begin
                            r_fstate   <= F_COMMIT;
                            r_push_req <= is_move(w_s);
                        end else begin
                            r_fstate <= F_SETTLE;
                        end
                    end
                end
                F_SETTLE: begin
                    if (w_s != r_cand) begin
                        if (w_s == r_last) begin
                            r_fstate <= F_IDLE;
                        end else begin
                            r_cand <= w_s;
                            r_cnt  <= CNTW'(1);
                        end
                    end else if (r_cnt == CNTW'(STABLE_CYC - 1)) begin
                        r_fstate   <= F_COMMIT;
                        r_push_req <= is_move(r_cand);
                    end else begin
                        r_cnt <= r_cnt + CNTW'(1);
                    end
                end
                F_COMMIT: begin
                    r_last   <= r_cand;
                    r_fstate <= F_IDLE;
                end
                default: r_fstate <= F_IDLE;
            endcase
        end
    end

    // A tick only dequeues when the game is running and something is waiting.
    assign w_pop = game_tick && game_run && !w_empty;

    // Push qualification: compare against the most recent planned direction.
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        w_ref       = (w_count != '0) ? w_tail : r_cur_dir;
        w_accept    = r_push_req && (r_cand != w_ref) && (r_cand != reverse(w_ref));
        w_push      = w_accept && (!w_full || w_pop) && !flush;
        w_drop_full = w_accept && w_full && !w_pop;
    end

    dir_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_25),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_push  (w_push),
        .i_data  (r_cand),
        .i_pop   (w_pop && !flush),
        .o_head  (w_head),
        .o_tail  (w_tail),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Current direction, turn strobe and sticky overflow; flush overrides everything.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_dir    <= INIT_D;
            r_turn_pulse <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_turn_pulse <= 1'b0;
            if (flush) begin
                r_cur_dir  <= INIT_D;
                r_overflow <= 1'b0;
            end else begin
                if (w_pop) begin
                    r_cur_dir    <= w_head;
                    r_turn_pulse <= 1'b1;
                end
                if (w_drop_full) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign cur_dir    = r_cur_dir;
    assign turn_pulse = r_turn_pulse;
    assign pending    = w_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_snake_dir_scheduler.sv
// Self-checking bench for snake_dir_scheduler against a turn-queue reference model.
module tb_snake_dir_scheduler;

    localparam int DEPTH = 4;
    localparam int HOLD  = 8;

    logic       clk_25 = 1'b0;
    logic       rst_n  = 1'b0;
    logic [2:0] kb_dir = 3'd4;
    logic       game_tick = 1'b0;
    logic       game_run  = 1'b1;
    logic       flush     = 1'b0;
    logic [2:0] cur_dir;
    logic       turn_pulse;
    logic [2:0] pending;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int latency  = 6;

    // Reference model: queue of planned turns, direction in force, last committed key.
    int m_q[$];
    int m_cur;
    int m_last;
    bit m_ovf;

    snake_dir_scheduler #(.DEPTH(DEPTH), .STABLE_CYC(3), .INIT_DIR(3'd1)) dut (
        .clk_25     (clk_25),
        .rst_n      (rst_n),
        .kb_dir     (kb_dir),
        .game_tick  (game_tick),
        .game_run   (game_run),
        .flush      (flush),
        .cur_dir    (cur_dir),
        .turn_pulse (turn_pulse),
        .pending    (pending),
        .overflow   (overflow)
    );

    always #20 clk_25 = ~clk_25;

    function automatic int norm(int d);
        return (d > 4) ? 4 : d;
    endfunction

    function automatic int rev(int d);
        case (d)
            0: return 3;
            3: return 0;
            1: return 2;
            2: return 1;
            default: return 4;
        endcase
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_cur  = 1;
        m_last = 4;
        m_ovf  = 0;
    endtask

    task automatic m_commit(input int d);
        int n, r;
        n = norm(d);
        if (n == m_last) return;
        m_last = n;
        if (n == 4) return;
        r = (m_q.size() > 0) ? m_q[$] : m_cur;
        if (n == r || n == rev(r)) return;
        if (m_q.size() == DEPTH) m_ovf = 1;
        else m_q.push_back(n);
    endtask

    task automatic step();
        @(posedge clk_25);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; kb_dir = 3'd4; game_tick = 1'b0; flush = 1'b0; game_run = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        m_reset();
    endtask

    task automatic press(input int d);
        kb_dir = d[2:0];
        repeat (HOLD) step();
        m_commit(d);
    endtask

    task automatic tick(input bit run, output bit exp_pulse);
        game_tick = 1'b1; game_run = run;
        step();
        game_tick = 1'b0; game_run = 1'b1;
        exp_pulse = run && (m_q.size() > 0);
        if (exp_pulse) m_cur = m_q.pop_front();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        m_q.delete();
        m_cur = 1;
        m_ovf = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (cur_dir !== 3'd1) begin n_fail++; $display("FAIL reset_cur_dir: got %0d want 1", cur_dir); end
        n_checks++; if (pending !== 3'd0) begin n_fail++; $display("FAIL reset_pending: got %0d want 0", pending); end
        n_checks++; if (turn_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_turn_pulse: got %b want 0", turn_pulse); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_single_turn();
        int seen;
        bit ep;
        do_reset();
        kb_dir = 3'd3;
        seen = -1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 3) begin
                n_checks++; if (pending !== 3'd0) begin n_fail++; $display("FAIL early_push: got %0d want 0", pending); end
            end
            if (pending == 3'd1 && seen < 0) seen = i;
        end
        m_commit(3);
        n_checks++; if (seen < 0) begin n_fail++; $display("FAIL turn_queued: pending never reached 1 within 10 cycles (got %0d)", pending); end
        else latency = seen;
        tick(1'b1, ep);
        n_checks++; if (cur_dir !== 3'(m_cur)) begin n_fail++; $display("FAIL single_cur_dir: got %0d want %0d", cur_dir, m_cur); end
        n_checks++; if (turn_pulse !== ep) begin n_fail++; $display("FAIL single_pulse: got %b want %b", turn_pulse, ep); end
        n_checks++; if (pending !== 3'(m_q.size())) begin n_fail++; $display("FAIL single_pending: got %0d want %0d", pending, m_q.size()); end
        step();
        n_checks++; if (turn_pulse !== 1'b0) begin n_fail++; $display("FAIL pulse_width: got %b want 0", turn_pulse); end
    endtask

    task automatic test_reversal();
        do_reset();
        press(2);
        press(4);
        press(2);
        n_checks++; if (pending !== 3'(m_q.size())) begin n_fail++; $display("FAIL reversal_pending: got %0d want %0d", pending, m_q.size()); end
        n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL reversal_overflow: got %b want %b", overflow, m_ovf); end
        n_checks++; if (cur_dir !== 3'(m_cur)) begin n_fail++; $display("FAIL reversal_cur_dir: got %0d want %0d", cur_dir, m_cur); end
    endtask

    task automatic test_queue_overflow();
        bit ep;
        do_reset();
        press(3); press(2); press(0); press(1);
        n_checks++; if (pending !== 3'(m_q.size())) begin n_fail++; $display("FAIL queue_pending: got %0d want %0d", pending, m_q.size()); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL queue_no_overflow: got %b want 0", overflow); end
        press(3);
        n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL overflow_set: got %b want %b", overflow, m_ovf); end
        n_checks++; if (pending !== 3'(m_q.size())) begin n_fail++; $display("FAIL overflow_pending: got %0d want %0d", pending, m_q.size()); end
        tick(1'b0, ep);
        n_checks++; if (turn_pulse !== ep || cur_dir !== 3'(m_cur)) begin n_fail++; $display("FAIL paused_tick: pulse %b dir %0d want pulse %b dir %0d", turn_pulse, cur_dir, ep, m_cur); end
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, ep);
            n_checks++; if (cur_dir !== 3'(m_cur) || turn_pulse !== ep) begin n_fail++; $display("FAIL drain_%0d: dir %0d pulse %b want dir %0d pulse %b", i, cur_dir, turn_pulse, m_cur, ep); end
            step();
        end
        tick(1'b1, ep);
        n_checks++; if (turn_pulse !== ep || pending !== 3'd0) begin n_fail++; $display("FAIL empty_tick: pulse %b pending %0d want pulse %b pending 0", turn_pulse, pending, ep); end
    endtask

    task automatic test_toggle();
        bit ep;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            kb_dir = (i % 2 == 1) ? 3'd0 : 3'd3;
            step();
            n_checks++; if (pending !== 3'd0) begin n_fail++; $display("FAIL toggle_commit_%0d: pending %0d want 0", i, pending); end
        end
        press(0);
        n_checks++; if (pending !== 3'(m_q.size())) begin n_fail++; $display("FAIL toggle_settle: pending %0d want %0d", pending, m_q.size()); end
        tick(1'b1, ep);
        n_checks++; if (cur_dir !== 3'(m_cur) || turn_pulse !== ep) begin n_fail++; $display("FAIL toggle_apply: dir %0d pulse %b want dir %0d pulse %b", cur_dir, turn_pulse, m_cur, ep); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        press(3); press(2); press(0); press(1);
        kb_dir = 3'd3;
        repeat (latency - 1) step();
        game_tick = 1'b1;
        step();
        game_tick = 1'b0;
        m_cur = m_q.pop_front();
        m_commit(3);
        n_checks++; if (pending !== 3'(m_q.size())) begin n_fail++; $display("FAIL b2b_pending: got %0d want %0d", pending, m_q.size()); end
        n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL b2b_overflow: got %b want %b", overflow, m_ovf); end
        n_checks++; if (cur_dir !== 3'(m_cur) || turn_pulse !== 1'b1) begin n_fail++; $display("FAIL b2b_pop: dir %0d pulse %b want dir %0d pulse 1", cur_dir, turn_pulse, m_cur); end
        repeat (4) step();
    endtask

    task automatic test_flush_and_reset();
        bit ep;
        do_reset();
        press(3); press(2);
        n_checks++; if (pending !== 3'(m_q.size())) begin n_fail++; $display("FAIL preflush_pending: got %0d want %0d", pending, m_q.size()); end
        do_flush();
        n_checks++; if (pending !== 3'd0 || cur_dir !== 3'(m_cur) || overflow !== 1'b0) begin n_fail++; $display("FAIL flush: pending %0d dir %0d ovf %b want 0 %0d 0", pending, cur_dir, overflow, m_cur); end
        repeat (HOLD) step();
        n_checks++; if (pending !== 3'(m_q.size())) begin n_fail++; $display("FAIL held_key_requeued: pending %0d want %0d", pending, m_q.size()); end
        press(3);
        tick(1'b1, ep);
        step();
        press(2);
        n_checks++; if (pending !== 3'(m_q.size()) || cur_dir !== 3'(m_cur)) begin n_fail++; $display("FAIL prereset_state: pending %0d dir %0d want %0d %0d", pending, cur_dir, m_q.size(), m_cur); end
        kb_dir = 3'd0;
        repeat (4) step();
        #5 rst_n = 1'b0;
        #1;
        n_checks++; if (cur_dir !== 3'd1 || pending !== 3'd0 || turn_pulse !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: dir %0d pending %0d pulse %b ovf %b want 1 0 0 0", cur_dir, pending, turn_pulse, overflow);
        end
        kb_dir = 3'd4;
        step();
        rst_n = 1'b1;
        m_reset();
        repeat (HOLD) step();
        n_checks++; if (pending !== 3'd0 || cur_dir !== 3'(m_cur)) begin n_fail++; $display("FAIL partial_commit: pending %0d dir %0d want 0 %0d", pending, cur_dir, m_cur); end
    endtask

    task automatic test_random();
        bit ep;
        int op;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 9);
            ep = 1'b0;
            if (op < 6) press($urandom_range(0, 7));
            else if (op < 9) tick(1'($urandom_range(0, 3) != 0), ep);
            else do_flush();
            n_checks++; if (pending !== 3'(m_q.size()) || cur_dir !== 3'(m_cur) || overflow !== m_ovf || turn_pulse !== ep) begin
                n_fail++;
                $display("FAIL random_%0d op %0d: pending %0d dir %0d ovf %b pulse %b want %0d %0d %b %b",
                         i, op, pending, cur_dir, overflow, turn_pulse, m_q.size(), m_cur, m_ovf, ep);
            end
            step();
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_single_turn();
        test_reversal();
        test_queue_overflow();
        test_toggle();
        test_back_to_back();
        test_flush_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
